// File: rtl/data_mem_lsu.sv
// Load/store unit between execute and a byte-laned synchronous data memory.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses instead of aligning them.
module data_mem_lsu #(
  parameter int WIDTH = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [WIDTH-3:0]  mem_address,
  output logic              mem_write_enable,
  output logic [3:0]        mem_mask_byte,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no back-pressure.
  state_t      state;
  logic        write_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        accept;
  logic        misaligned;
  logic [1:0]  off_c;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] load_c;
  logic        unused_addr_bits;

  assign accept           = req_valid && req_ready;
  assign req_ready        = (state == IDLE);
  assign dbg_state        = state;
  assign unused_addr_bits = ^req_addr[31:WIDTH];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Effective byte offset: halves and words are forced onto natural alignment.
  always_comb begin
    off_c   = 2'b00;
    mask_c  = 4'b1111;
    wdata_c = req_wdata;
    case (req_size)
      2'b00: begin
        off_c   = req_addr[1:0];
        mask_c  = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        off_c   = {req_addr[1], 1'b0};
        mask_c  = 4'b0011 << {req_addr[1], 1'b0};
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        off_c   = 2'b00;
        mask_c  = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  assign shifted = mem_read_data >> {off_q, 3'b000};

  always_comb begin
    load_c = shifted;
    case (size_q)
      2'b00:   load_c = unsigned_q ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_c = unsigned_q ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_c = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      write_q          <= 1'b0;
      unsigned_q       <= 1'b0;
      size_q           <= 2'b00;
      off_q            <= 2'b00;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'b0;
      resp_misaligned  <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_mask_byte    <= 4'b0;
      mem_write_data   <= 32'b0;
    end else begin
      // The memory command exists only during ACCESS.
      resp_valid       <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_mask_byte    <= 4'b0;
      mem_write_data   <= 32'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            off_q      <= off_c;
            if (misaligned) begin
              state           <= RESP;
              resp_valid      <= 1'b1;
              resp_rdata      <= 32'b0;
              resp_misaligned <= 1'b1;
            end else begin
              state       <= ACCESS;
              mem_address <= req_addr[WIDTH-1:2];
              if (req_write) begin
                mem_write_enable <= 1'b1;
                mem_mask_byte    <= mask_c;
                mem_write_data   <= wdata_c;
              end
            end
          end
        end
        ACCESS: begin
          if (write_q) begin
            state           <= RESP;
            resp_valid      <= 1'b1;
            resp_rdata      <= 32'b0;
            resp_misaligned <= 1'b0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state           <= RESP;
          resp_valid      <= 1'b1;
          resp_rdata      <= load_c;
          resp_misaligned <= 1'b0;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
